serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
//-----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder/subtractor controller. A request is captured in IDLE.
// One 1-bit full adder then processes the operands LSB first, one bit per
// clock, for exactly WIDTH cycles in RUN. The result is presented in DONE
// until the consumer accepts it.
//
// Subtraction is done as A + ~B + 1: B is inverted on capture and the carry
// is seeded with in_sub.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   controller can accept a request (state IDLE)
//   in_a       operand A
//   in_b       operand B
//   in_sub     1 = A-B, 0 = A+B
//   out_valid  result available (state DONE)
//   out_ready  consumer accepts result
//   out_sum    result bits
//   out_cout   final carry (subtract: 1 = no borrow, A >= B unsigned)
//   out_ovf    two's-complement signed overflow
//   busy       high while the serial addition runs (state RUN)
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

//-----------------------------------------------------------------------------
// full_adder
//
// Combinational 1-bit full adder.
//
// Ports:
//   X, Y  addend bits
//   Ci    carry in
//   S     sum bit
//   Co    carry out
//-----------------------------------------------------------------------------
module full_adder (
    input  logic X,
    input  logic Y,
    input  logic Ci,
    output logic S,
    output logic Co
);

    assign S  = X ^ Y ^ Ci;
    assign Co = (X & Y) | (Ci & (X ^ Y));

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    // One extra counter bit means the count can reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   result;
    logic               carry;
    logic               c_msb_in;
    logic [CNT_W-1:0]   bit_cnt;

    logic               accept;
    logic               last_bit;
    logic               fa_s;
    logic               fa_co;

    // The single full adder is reused on every RUN cycle.
    full_adder u_fa (
        .X  (a_sr[0]),
        .Y  (b_sr[0]),
        .Ci (carry),
        .S  (fa_s),
        .Co (fa_co)
    );

    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // The DONE -> IDLE handshake lands in IDLE, so a new request can only be
    // accepted on the following edge.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath.
    // On capture, B is pre-inverted and the carry is seeded for subtraction.
    // In RUN, the sum bit enters the result MSB so that after WIDTH shifts
    // bit 0 has reached position 0. The carry into the MSB step is kept for
    // overflow detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            result   <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            bit_cnt  <= '0;
        end else if (accept) begin
            a_sr    <= in_a;
            b_sr    <= in_b ^ {WIDTH{in_sub}};
            carry   <= in_sub;
            bit_cnt <= '0;
        end else if (state == RUN) begin
            result  <= {fa_s, result[WIDTH-1:1]};
            carry   <= fa_co;
            a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
                c_msb_in <= carry;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign out_sum   = result;
    assign out_cout  = carry;
    assign out_ovf   = c_msb_in ^ carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
//-----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed testbench for serial_add_ctrl with WIDTH = 8. Expected results
// are hand-computed constants.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       out_ovf;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until out_valid, bounded
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Full transaction: accept, scramble inputs during RUN, check latency,
    // result and the handshake back to IDLE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic [7:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        int lat;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_sub   = ~sub;
        check_bit({tag, "_busy"}, busy, 1'b1);
        wait_valid(lat);
        check_int({tag, "_latency"}, lat, 8);
        check_word({tag, "_sum"}, out_sum, exp_sum);
        check_bit({tag, "_cout"}, out_cout, exp_cout);
        check_bit({tag, "_ovf"}, out_ovf, exp_ovf);
        check_bit({tag, "_in_ready_done"}, in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_bit({tag, "_valid_drop"}, out_valid, 1'b0);
        check_bit({tag, "_in_ready_idle"}, in_ready, 1'b1);
    endtask

    // Main directed sequence
    initial begin
        int lat;
        logic [7:0] bb_a    [3] = '{8'h7F, 8'h05, 8'hC0};
        logic [7:0] bb_b    [3] = '{8'h01, 8'h07, 8'hC0};
        logic       bb_sub  [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] bb_sum  [3] = '{8'h80, 8'hFE, 8'h80};
        logic       bb_cout [3] = '{1'b0, 1'b0, 1'b1};
        logic       bb_ovf  [3] = '{1'b1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_word("rst_sum", out_sum, 8'h00);
        check_bit("rst_cout", out_cout, 1'b0);
        check_bit("rst_ovf", out_ovf, 1'b0);
        rst_n = 1'b1;
        tick();
        check_bit("post_rst_in_ready", in_ready, 1'b1);
        check_bit("post_rst_busy", busy, 1'b0);

        // out_ready with nothing pending changes nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_bit("idle_ready_out_valid", out_valid, 1'b0);
        check_bit("idle_ready_in_ready", in_ready, 1'b1);

        // Directed arithmetic vectors
        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("sub_20_20", 8'h20, 8'h20, 1'b1, 8'h00, 1'b1, 1'b0);

        // Backpressure: result held for 5 cycles, in_valid pulses ignored
        in_a     = 8'h12;
        in_b     = 8'h34;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check_int("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_a     = 8'hEE;
            in_b     = 8'hEE;
            tick();
            check_bit("bp_out_valid", out_valid, 1'b1);
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_word("bp_sum", out_sum, 8'h46);
            check_bit("bp_cout", out_cout, 1'b0);
            check_bit("bp_ovf", out_ovf, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_bit("bp_release_valid", out_valid, 1'b0);
        check_bit("bp_release_in_ready", in_ready, 1'b1);
        tick();
        check_bit("bp_no_accept_busy", busy, 1'b0);

        // Reset in the middle of RUN (bit 3 in progress)
        in_a     = 8'hAA;
        in_b     = 8'h55;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check_bit("midrun_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("midrun_rst_out_valid", out_valid, 1'b0);
        check_bit("midrun_rst_busy", busy, 1'b0);
        check_word("midrun_rst_sum", out_sum, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("after_rst_add", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // Back-to-back with in_valid held high; next operands presented
        // during RUN must not disturb the current result.
        in_a     = bb_a[0];
        in_b     = bb_b[0];
        in_sub   = bb_sub[0];
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_bit("b2b_busy", busy, 1'b1);
            if (k < 2) begin
                in_a   = bb_a[k+1];
                in_b   = bb_b[k+1];
                in_sub = bb_sub[k+1];
            end else begin
                in_a   = 8'hFF;
                in_b   = 8'hFF;
                in_sub = 1'b1;
            end
            wait_valid(lat);
            check_int("b2b_latency", lat, 8);
            check_word("b2b_sum", out_sum, bb_sum[k]);
            check_bit("b2b_cout", out_cout, bb_cout[k]);
            check_bit("b2b_ovf", out_ovf, bb_ovf[k]);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (k == 2) begin
                in_valid = 1'b0;
            end
            check_bit("b2b_in_ready", in_ready, 1'b1);
            check_bit("b2b_not_busy", busy, 1'b0);
        end
        tick();
        check_bit("b2b_end_idle", in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
